boost_pwm_gen: RTL and testbench
================================

BOOST_PWM_GEN -- requirements
Module: boost_pwm_gen

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of complementary PWM channels, range 1..8.
REQ-002 SHALL have parameter DW, default 10: duty width in bits; PWM period = 2^DW ticks.
REQ-003 SHALL have parameter PRESC, default 200: clk cycles per tick, range 2..65535.
REQ-004 SHALL have parameter DT, default 4: deadtime in ticks, range 0..2^DW-1.
REQ-005 SHALL have parameter INT_TICKS, default 500: interrupt period in ticks; even, range 2..16383.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ce, input, 1 bit: run enable.
REQ-009 SHALL have port d, input, N_CH*DW bits: duty words; channel k at bits [k*DW +: DW].
REQ-010 SHALL have port s, output, N_CH bits: high-side gate drives, registered.
REQ-011 SHALL have port nots, output, N_CH bits: low-side gate drives, registered.
REQ-012 SHALL have port clk_int, output, 1 bit: 50 % interrupt square wave, registered.
REQ-013 SHALL have port irq, output, 1 bit: one-clk interrupt strobe, registered.

Function
REQ-014 SHALL count prescaler pre 0..PRESC-1 while ce=1 and assert internal tick for one clk when pre==PRESC-1, then wrap pre to 0.
REQ-015 SHALL have no derived clocks; all tick-rate logic SHALL use tick as a clock enable.
REQ-016 SHALL advance PWM counter cnt (DW bits) by 1 on each tick and wrap from 2^DW-1 to 0.
REQ-017 SHALL load shadow duty dsh[k] from d[k] on the tick where cnt wraps to 0; d changes mid-period SHALL have no effect until the next period.
REQ-018 SHALL compute raw[k] = (cnt < dsh[k]), with cnt and dsh[k] after the tick update: dsh=0 gives raw constantly 0; dsh=2^DW-1 gives raw low for one tick per period.
REQ-019 SHALL handle a rising edge of raw[k] as follows: nots[k]=0 one clk after the tick; s[k]=1 one clk after the DT-th subsequent tick, if raw[k] is still 1.
REQ-020 SHALL handle a falling edge of raw[k] symmetrically: s[k]=0 after one clk; nots[k]=1 after DT ticks.
REQ-021 SHALL never drive s[k] and nots[k] high in the same clk, under any input sequence.
REQ-022 SHALL, when a raw pulse is shorter than DT ticks, never assert the incoming output during that pulse; both outputs stay 0 until a state persists DT ticks.
REQ-023 SHALL, with DT=0, drive s[k]=raw[k] and nots[k]=~raw[k], registered one clk after tick.
REQ-024 SHALL count interrupt counter ic 0..INT_TICKS-1 on tick, wrapping to 0.
REQ-025 SHALL drive clk_int=1 while ic < INT_TICKS/2 and 0 otherwise.
REQ-026 SHALL pulse irq for exactly one clk when ic wraps to 0.
REQ-027 SHALL, when ce=0, freeze pre, cnt, ic, dsh and clk_int, force s=0 and nots=0 on the next clk, clear the deadtime counters, and keep irq at 0.
REQ-028 SHALL, when ce returns to 1, resume counting from the frozen values and apply a full DT-tick deadtime before asserting any output.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously hold pre=0, cnt=0, ic=0, dsh=0, deadtime counters=0, s=0, nots=0, clk_int=0, irq=0.
REQ-030 SHALL, on rst_n release, start counting on the first clk edge with ce=1; the first tick occurs PRESC clks later.
REQ-031 SHALL, if reset is asserted mid-period or mid-deadtime, force outputs low immediately, without waiting for the clock.

Structure
REQ-032 SHALL place the parameter range limits and the deadtime state encoding (OFF, DT_WAIT, ON) in shared package boost_pkg.
REQ-033 SHALL instantiate sub-module pwm_channel N_CH times, one per channel, each holding dsh, the compare, the deadtime counter and the s/nots registers.
REQ-034 SHALL keep the prescaler, cnt, ic and irq/clk_int logic single-instance in boost_pwm_gen, with tick and cnt broadcast to the channels.

Verification (bench: N_CH=2, DW=4, PRESC=2, DT=2, INT_TICKS=8)
REQ-035 SHALL check: d0=8, d1=0, ce=1 for 3 periods -> s0 high 6 ticks per 16, nots0 high 6 ticks, 2-tick gaps both low at each edge; s1=0 throughout, nots1=1 after the initial 2 ticks.
REQ-036 SHALL check: d0 changed 4->12 at cnt=5 -> current period keeps a 4-tick raw width; the next period uses 12.
REQ-037 SHALL check: d0=1, so raw0 pulse = 1 tick < DT -> s0 never 1; nots0 low for 3 ticks per period.
REQ-038 SHALL check: ce=1 for 40 clks -> clk_int toggles every 4 ticks (8 clks), irq one-clk pulse every 16 clks, first pulse at ic wrap.
REQ-039 SHALL check: ce dropped at cnt=6 for 10 clks, then raised -> s=nots=0 during the drop, cnt holds 6, 2-tick deadtime before any output reasserts.
REQ-040 SHALL check: rst_n pulsed low between clk edges while s0=1 -> s0, nots0, clk_int and irq fall with no clk edge; after release, counting restarts from cnt=0.

Source files
------------

// File: rtl/boost_pkg.sv
// rtl/boost_pkg.sv - shared parameter limits and deadtime state encoding for boost_pwm_gen
package boost_pkg;

    localparam int N_CH_MIN      = 1;
    localparam int N_CH_MAX      = 8;
    localparam int PRESC_MIN     = 2;
    localparam int PRESC_MAX     = 65535;
    localparam int INT_TICKS_MIN = 2;
    localparam int INT_TICKS_MAX = 16383;

    // OFF: outputs forced low, no level tracked yet (after reset or ce=0)
    // DT_WAIT: new level seen, both outputs low while it proves stable
    // ON: the output matching the tracked level is driven
    typedef enum logic [1:0] {
        OFF     = 2'd0,
        DT_WAIT = 2'd1,
        ON      = 2'd2
    } dt_state_e;

    function automatic logic params_ok(input int n_ch, input int dw, input int presc,
                                       input int dt, input int int_ticks);
        return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
               (presc >= PRESC_MIN) && (presc <= PRESC_MAX) &&
               (dt >= 0) && (dt < (1 << dw)) &&
               (int_ticks >= INT_TICKS_MIN) && (int_ticks <= INT_TICKS_MAX) &&
               ((int_ticks % 2) == 0);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one complementary PWM channel: shadow duty, compare, deadtime, gate registers
module pwm_channel
    import boost_pkg::*;
#(
    parameter int DW = 10,
    parameter int DT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          tick,
    input  logic [DW-1:0] cnt,
    input  logic [DW-1:0] d,
    output logic          s,
    output logic          nots
);

    localparam int CW = DW + 1;
    localparam logic [CW-1:0] DT_W = CW'(DT);

    dt_state_e     state;
    logic          lvl;
    logic [DW-1:0] dsh;
    logic [CW-1:0] dtc;

    logic [DW-1:0] cnt_nx;
    logic [DW-1:0] dsh_nx;
    logic          raw_nx;
    logic [CW-1:0] dtc_inc;
    logic [CW-1:0] dtc_start;

    // Compare uses the counter and shadow duty as they will be after this tick
    assign cnt_nx    = cnt + DW'(1);
    assign dsh_nx    = (cnt_nx == '0) ? d : dsh;
    assign raw_nx    = cnt_nx < dsh_nx;
    assign dtc_inc   = dtc + CW'(1);
    // Leaving OFF counts the first tick as deadtime; a true edge starts from zero
    assign dtc_start = (state == OFF) ? CW'(1) : '0;

    // Deadtime state machine and registered gate drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            lvl   <= 1'b0;
            dsh   <= '0;
            dtc   <= '0;
            s     <= 1'b0;
            nots  <= 1'b0;
        end else if (!ce) begin
            state <= OFF;
            dtc   <= '0;
            s     <= 1'b0;
            nots  <= 1'b0;
        end else if (tick) begin
            dsh <= dsh_nx;
            if ((state != OFF) && (raw_nx == lvl)) begin
                if (state == DT_WAIT) begin
                    dtc <= dtc_inc;
                    if (dtc_inc >= DT_W) begin
                        state <= ON;
                        s     <= lvl;
                        nots  <= ~lvl;
                    end
                end
            end else begin
                lvl <= raw_nx;
                dtc <= dtc_start;
                if (dtc_start >= DT_W) begin
                    state <= ON;
                    s     <= raw_nx;
                    nots  <= ~raw_nx;
                end else begin
                    state <= DT_WAIT;
                    s     <= 1'b0;
                    nots  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/boost_pwm_gen.sv
// rtl/boost_pwm_gen.sv - multi-channel complementary PWM with deadtime and periodic interrupt
module boost_pwm_gen
    import boost_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DW        = 10,
    parameter int PRESC     = 200,
    parameter int DT        = 4,
    parameter int INT_TICKS = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [N_CH*DW-1:0] d,
    output logic [N_CH-1:0]    s,
    output logic [N_CH-1:0]    nots,
    output logic               clk_int,
    output logic               irq
);

    localparam int PW = $clog2(PRESC);
    localparam int IW = $clog2(INT_TICKS);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);
    localparam logic [IW-1:0] IC_LAST  = IW'(INT_TICKS - 1);
    localparam logic [IW-1:0] IC_HALF  = IW'(INT_TICKS / 2);

    if (!params_ok(N_CH, DW, PRESC, DT, INT_TICKS)) begin : g_param_check
        $error("boost_pwm_gen: parameter out of range");
    end

    logic [PW-1:0] pre;
    logic          tick;
    logic [DW-1:0] cnt;
    logic [IW-1:0] ic;
    logic [IW-1:0] ic_nx;

    assign tick  = ce && (pre == PRE_LAST);
    assign ic_nx = (ic == IC_LAST) ? '0 : ic + IW'(1);

    // Prescaler: free-running while enabled, frozen otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (ce) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    // PWM counter, interrupt counter and interrupt outputs, all tick-enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ic      <= '0;
            clk_int <= 1'b0;
            irq     <= 1'b0;
        end else begin
            irq <= tick && (ic == IC_LAST);
            if (tick) begin
                cnt     <= cnt + DW'(1);
                ic      <= ic_nx;
                clk_int <= ic_nx < IC_HALF;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_channel #(
            .DW (DW),
            .DT (DT)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .tick  (tick),
            .cnt   (cnt),
            .d     (d[k*DW +: DW]),
            .s     (s[k]),
            .nots  (nots[k])
        );
    end

endmodule

// File: tb/tb_boost_pwm_gen.sv
// tb/tb_boost_pwm_gen.sv - self-checking bench for boost_pwm_gen
module tb_boost_pwm_gen;

    localparam int N_CH      = 2;
    localparam int DW        = 4;
    localparam int PRESC     = 2;
    localparam int DT        = 2;
    localparam int INT_TICKS = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ce;
    logic [N_CH*DW-1:0] d;
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  nots;
    logic             clk_int;
    logic             irq;

    boost_pwm_gen #(
        .N_CH      (N_CH),
        .DW        (DW),
        .PRESC     (PRESC),
        .DT        (DT),
        .INT_TICKS (INT_TICKS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .d       (d),
        .s       (s),
        .nots    (nots),
        .clk_int (clk_int),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int          m_pre, m_cnt, m_ic, tk;
    int          m_dsh   [N_CH];
    int          m_lvl   [N_CH];
    int          m_quiet [N_CH];
    bit          m_off   [N_CH];
    logic [N_CH-1:0] m_s, m_n;
    logic        m_ci, m_irq;
    bit          m_tick;

    logic [5:0]  sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_ic = 0; tk = 0;
        m_s = '0; m_n = '0; m_ci = 1'b0; m_irq = 1'b0; m_tick = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            m_dsh[k] = 0; m_lvl[k] = 0; m_quiet[k] = 0; m_off[k] = 1'b1;
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_edge();
        int raw;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_tick = ce && (m_pre == PRESC - 1);
        if (ce) m_pre = (m_pre == PRESC - 1) ? 0 : m_pre + 1;
        m_irq = 1'b0;
        if (m_tick) begin
            tk++;
            m_cnt = (m_cnt + 1) % (1 << DW);
            m_ic  = (m_ic + 1) % INT_TICKS;
            m_ci  = (m_ic < INT_TICKS / 2);
            m_irq = (m_ic == 0);
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!ce) begin
                m_off[k] = 1'b1; m_s[k] = 1'b0; m_n[k] = 1'b0;
            end else if (m_tick) begin
                if (m_cnt == 0) m_dsh[k] = int'(d[k*DW +: DW]);
                raw = (m_cnt < m_dsh[k]) ? 1 : 0;
                if (m_off[k]) begin
                    m_off[k] = 1'b0; m_quiet[k] = 1; m_lvl[k] = raw;
                end else if (raw != m_lvl[k]) begin
                    m_lvl[k] = raw; m_quiet[k] = 0;
                end else if (m_quiet[k] < DT) begin
                    m_quiet[k]++;
                end
                m_s[k] = (m_quiet[k] >= DT) && (raw == 1);
                m_n[k] = (m_quiet[k] >= DT) && (raw == 0);
            end
        end
    endtask

    task automatic step();
        logic [5:0] e;
        model_edge();
        sb_q.push_back({m_s, m_n, m_ci, m_irq});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("scoreboard", {s, nots, clk_int, irq}, e);
        check("overlap", s & nots, 0);
    endtask

    task automatic step_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick && n < PRESC + 2);
        if (!m_tick) begin
            n_chk++;
            n_fail++;
            $error("FAIL tick_timeout: observed no tick in %0d clks expected %0d", n, PRESC);
        end
    endtask

    task automatic count_period(input int chg_at, input logic [DW-1:0] chg_val,
                                output int sc, output int nc);
        sc = 0; nc = 0;
        for (int j = 0; j < (1 << DW); j++) begin
            step_tick();
            if (j == chg_at) d[DW-1:0] = chg_val;
            sc += int'(s[0]);
            nc += int'(nots[0]);
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int irq_q[$];
        int tog_q[$];
        int first_n1, s1_hi, sc, nc, rise_at, fall_at;
        int p2_s, p2_n, p2_z, p3_s, p3_n, p3_z;
        logic prev_ci;

        rst_n = 1'b0; ce = 1'b0; d = '0;
        model_reset();
        step();
        step();
        check("rst_s", s, 0);
        check("rst_nots", nots, 0);
        check("rst_clk_int", clk_int, 0);
        check("rst_irq", irq, 0);

        // d0=8, d1=0: steady complementary waveform and interrupt timing
        rst_n = 1'b1; ce = 1'b1; d = 8'h08;
        first_n1 = -1; s1_hi = 0; prev_ci = 1'b0;
        p2_s = 0; p2_n = 0; p2_z = 0; p3_s = 0; p3_n = 0; p3_z = 0;
        for (int i = 1; i <= 158; i++) begin
            step();
            if (irq) irq_q.push_back(i);
            if (clk_int !== prev_ci) tog_q.push_back(i);
            prev_ci = clk_int;
            if (m_tick) begin
                if (nots[1] && first_n1 < 0) first_n1 = tk;
                s1_hi += int'(s[1]);
                if (tk >= 16 && tk <= 31) begin
                    p2_s += int'(s[0]); p2_n += int'(nots[0]); p2_z += int'(!s[0] && !nots[0]);
                end
                if (tk >= 32 && tk <= 47) begin
                    p3_s += int'(s[0]); p3_n += int'(nots[0]); p3_z += int'(!s[0] && !nots[0]);
                end
            end
        end
        check("nots1_first_tick", first_n1, 2);
        check("s1_high_ticks", s1_hi, 0);
        check("p2_s0_ticks", p2_s, 6);
        check("p2_nots0_ticks", p2_n, 6);
        check("p2_gap_ticks", p2_z, 4);
        check("p3_s0_ticks", p3_s, 6);
        check("p3_nots0_ticks", p3_n, 6);
        check("p3_gap_ticks", p3_z, 4);
        check("irq_count", irq_q.size(), 9);
        foreach (irq_q[j]) check("irq_clk", irq_q[j], 16 * (j + 1));
        check("clk_int_toggles", tog_q.size(), 20);
        foreach (tog_q[j]) check("clk_int_toggle_clk", tog_q[j], (j == 0) ? 2 : 8 * j);

        // duty change mid-period only takes effect next period
        d[3:0] = 4'd4;
        count_period(5, 4'd12, sc, nc);
        check("d4_s0_ticks", sc, 2);
        check("d4_nots0_ticks", nc, 10);
        count_period(-1, 4'd0, sc, nc);
        check("d12_s0_ticks", sc, 10);
        check("d12_nots0_ticks", nc, 2);

        // pulse shorter than the deadtime never reaches the gate
        d[3:0] = 4'd1;
        count_period(-1, 4'd0, sc, nc);
        check("d1_s0_ticks", sc, 0);
        check("d1_nots0_low_ticks", 16 - nc, 3);

        // ce drop at cnt=6, then resume with a fresh deadtime
        d[3:0] = 4'd12;
        for (int j = 0; j < 20 && m_cnt != 6; j++) step_tick();
        check("s0_before_drop", s[0], 1);
        ce = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            check("drop_gates", {s, nots}, 0);
            check("drop_irq", irq, 0);
        end
        ce = 1'b1;
        rise_at = -1; fall_at = -1;
        for (int j = 1; j <= 16; j++) begin
            step_tick();
            if (s[0] && rise_at < 0) rise_at = j;
            if (rise_at >= 0 && !s[0] && fall_at < 0) fall_at = j;
        end
        check("resume_s0_rise_tick", rise_at, 2);
        check("resume_s0_fall_tick", fall_at, 6);

        // asynchronous reset between clock edges while s0 is high
        check("s0_before_reset", s[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s0", s[0], 0);
        check("async_rst_nots0", nots[0], 0);
        check("async_rst_clk_int", clk_int, 0);
        check("async_rst_irq", irq, 0);
        model_reset();
        step();
        rst_n = 1'b1;
        d = 8'h08;
        rise_at = -1;
        for (int j = 0; j < 40 && rise_at < 0; j++) begin
            step_tick();
            if (s[0]) rise_at = tk;
        end
        check("post_reset_s0_rise_tick", rise_at, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
